// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back front end.
// The entry record is sized by the default widths and used by any code that runs at those widths.
package wb_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular buffer of write-back results.
// It exposes per-entry valid/register so the top can build the pending mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push0_i,
  input  logic [AW-1:0]             push0_reg_i,
  input  logic [DW-1:0]             push0_data_i,
  input  logic                      push1_i,
  input  logic [AW-1:0]             push1_reg_i,
  input  logic [DW-1:0]             push1_data_i,
  input  logic                      pop_i,
  output logic [CW-1:0]             count_o,
  output logic [AW-1:0]             head_reg_o,
  output logic [DW-1:0]             head_data_o,
  output logic [DEPTH-1:0]          ent_valid_o,
  output logic [DEPTH-1:0][AW-1:0]  ent_reg_o
);

  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;
  logic [DEPTH-1:0][AW-1:0]  reg_q;
  logic [DEPTH-1:0][DW-1:0]  data_q;
  logic [PW-1:0]             tailNext;
  logic                      popEn;

  // push1 is only ever asserted together with push0, so it lands one slot after the tail.
  always_comb begin
    popEn    = pop_i && (count_q != '0);
    tailNext = tail_q + PW'(1);
    head_d   = popEn ? (head_q + PW'(1)) : head_q;
    tail_d   = tail_q + PW'(push0_i) + PW'(push1_i);
    count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(popEn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_i) begin
      reg_q[tail_q]  <= push0_reg_i;
      data_q[tail_q] <= push0_data_i;
    end
    if (push1_i) begin
      reg_q[tailNext]  <= push1_reg_i;
      data_q[tailNext] <= push1_data_i;
    end
  end

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    logic [PW-1:0] offset;
    offset      = '0;
    ent_valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PW'(i) - head_q;
      ent_valid_o[i] = ({1'b0, offset} < count_q);
    end
  end

  assign ent_reg_o   = reg_q;
  assign count_o     = count_q;
  assign head_reg_o  = reg_q[head_q];
  assign head_data_o = data_q[head_q];

endmodule

// File: rtl/reg_writeback.sv
// Write-side front end of the register file: merges MEM and ALU results in order,
// drives the single write port and publishes which registers still have writes in flight.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_valid,
  input  logic [AW-1:0]  mem_reg,
  input  logic [DW-1:0]  mem_data,
  input  logic           alu_valid,
  input  logic [AW-1:0]  alu_reg,
  input  logic [DW-1:0]  alu_data,
  output logic           in_ready,
  output logic [AW-1:0]  wr_reg,
  output logic [DW-1:0]  wr_data,
  output logic           wr_en,
  output logic [31:0]    pending_mask,
  output logic           overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]             count;
  logic [AW-1:0]             headReg;
  logic [DW-1:0]             headData;
  logic [DEPTH-1:0]          entValid;
  logic [DEPTH-1:0][AW-1:0]  entReg;

  logic           memLive, aluLive, memTake, aluTake;
  logic           push0, push1, pop;
  logic [AW-1:0]  push0Reg;
  logic [DW-1:0]  push0Data;

  logic           wrEn_q, wrEn_d;
  logic [AW-1:0]  wrReg_q, wrReg_d;
  logic [DW-1:0]  wrData_q, wrData_d;
  logic           overflow_q, overflow_d;

  // Room for two is required so a dual push can never overrun, regardless of this cycle's pop.
  assign in_ready = (count <= CW'(DEPTH - 2));

  // MEM goes first when both arrive: the load is the older instruction.
  always_comb begin
    memLive   = mem_valid && (mem_reg != AW'(REG_ZERO));
    aluLive   = alu_valid && (alu_reg != AW'(REG_ZERO));
    memTake   = memLive && in_ready;
    aluTake   = aluLive && in_ready;
    push0     = memTake || aluTake;
    push1     = memTake && aluTake;
    push0Reg  = memTake ? mem_reg : alu_reg;
    push0Data = memTake ? mem_data : alu_data;
    pop       = (count != '0);
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push0_i      (push0),
    .push0_reg_i  (push0Reg),
    .push0_data_i (push0Data),
    .push1_i      (push1),
    .push1_reg_i  (alu_reg),
    .push1_data_i (alu_data),
    .pop_i        (pop),
    .count_o      (count),
    .head_reg_o   (headReg),
    .head_data_o  (headData),
    .ent_valid_o  (entValid),
    .ent_reg_o    (entReg)
  );

  always_comb begin
    wrEn_d     = pop;
    wrReg_d    = pop ? headReg : wrReg_q;
    wrData_d   = pop ? headData : wrData_q;
    overflow_d = overflow_q || ((memLive || aluLive) && !in_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrEn_q     <= 1'b0;
      wrReg_q    <= '0;
      wrData_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrEn_q     <= wrEn_d;
      wrReg_q    <= wrReg_d;
      wrData_q   <= wrData_d;
      overflow_q <= overflow_d;
    end
  end

  // The presented write stays pending until the register file commits it on the next edge.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entValid[i]) pending_mask = pending_mask | (32'(1) << entReg[i]);
    end
    if (wrEn_q) pending_mask = pending_mask | (32'(1) << wrReg_q);
  end

  assign wr_en    = wrEn_q;
  assign wr_reg   = wrReg_q;
  assign wr_data  = wrData_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: table-driven vectors plus hand sequences,
// with a scoreboard queue holding every accepted result until it appears on the write port.
module tb_reg_writeback;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           mem_valid, alu_valid;
  logic [AW-1:0]  mem_reg, alu_reg;
  logic [DW-1:0]  mem_data, alu_data;
  logic           in_ready, wr_en, overflow;
  logic [AW-1:0]  wr_reg;
  logic [DW-1:0]  wr_data;
  logic [31:0]    pending_mask;

  always #5 clk = ~clk;

  reg_writeback #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .alu_valid    (alu_valid),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .in_ready     (in_ready),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .pending_mask (pending_mask),
    .overflow     (overflow)
  );

  typedef struct {
    logic           mv;
    logic [AW-1:0]  mr;
    logic [DW-1:0]  md;
    logic           av;
    logic [AW-1:0]  ar;
    logic [DW-1:0]  ad;
    logic           expReady;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  wb_entry_t  expQ[$];
  logic       ovfModel = 1'b0;
  int         lastSize = 0;
  vec_t       tbl[14];

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compares every output against the scoreboard; called #1 after each rising edge.
  task automatic checkOutput();
    wb_entry_t   e;
    logic [31:0] expMask;
    expMask = '0;
    checkVal("wr_en", 32'(wr_en), 32'(lastSize != 0));
    if (wr_en === 1'b1 && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkVal("wr_reg", 32'(wr_reg), 32'(e.rd));
      checkVal("wr_data", wr_data, e.data);
      expMask = expMask | (32'(1) << e.rd);
    end
    foreach (expQ[i]) expMask = expMask | (32'(1) << expQ[i].rd);
    checkVal("pending_mask", pending_mask, expMask);
    checkVal("in_ready", 32'(in_ready), 32'(expQ.size() <= DEPTH - 2));
    checkVal("overflow", 32'(overflow), 32'(ovfModel));
    lastSize = expQ.size();
  endtask

  // Drives one cycle of pushes, records accepted results, then steps one edge and checks.
  task automatic applyStimulus(input vec_t v);
    logic      ready;
    wb_entry_t e;
    mem_valid = v.mv;  mem_reg = v.mr;  mem_data = v.md;
    alu_valid = v.av;  alu_reg = v.ar;  alu_data = v.ad;
    ready = (expQ.size() <= DEPTH - 2);
    checkVal("in_ready_vec", 32'(in_ready), 32'(v.expReady));
    if (v.mv && v.mr != 0) begin
      if (ready) begin
        e.rd = v.mr;  e.data = v.md;
        expQ.push_back(e);
      end else ovfModel = 1'b1;
    end
    if (v.av && v.ar != 0) begin
      if (ready) begin
        e.rd = v.ar;  e.data = v.ad;
        expQ.push_back(e);
      end else ovfModel = 1'b1;
    end
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    checkOutput();
  endtask

  task automatic idle(input int n);
    vec_t v;
    v = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1};
    for (int i = 0; i < n; i++) begin
      v.expReady = (expQ.size() <= DEPTH - 2);
      applyStimulus(v);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    ovfModel = 1'b0;
    lastSize = 0;
    checkVal("rst_wr_en", 32'(wr_en), 32'd0);
    checkVal("rst_mask", pending_mask, 32'd0);
    checkVal("rst_wr_reg", 32'(wr_reg), 32'd0);
    checkVal("rst_wr_data", wr_data, 32'd0);
    checkVal("rst_in_ready", 32'(in_ready), 32'd1);
    checkVal("rst_overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mem_valid = 1'b0;  mem_reg = '0;  mem_data = '0;
    alu_valid = 1'b0;  alu_reg = '0;  alu_data = '0;

    tbl[0]  = '{1'b1, 5'd3,  32'h11,        1'b1, 5'd3,  32'h22,        1'b1};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1};
    tbl[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1};
    tbl[5]  = '{1'b1, 5'd1,  32'h101,       1'b1, 5'd2,  32'h102,       1'b1};
    tbl[6]  = '{1'b1, 5'd4,  32'h104,       1'b1, 5'd5,  32'h105,       1'b1};
    tbl[7]  = '{1'b1, 5'd6,  32'h106,       1'b1, 5'd7,  32'h107,       1'b0};
    tbl[8]  = '{1'b1, 5'd4,  32'h108,       1'b1, 5'd4,  32'h109,       1'b1};
    tbl[9]  = '{1'b1, 5'd10, 32'h10A,       1'b0, 5'd0,  32'h0,         1'b0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd11, 32'h10B,       1'b1};
    tbl[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1};
    tbl[12] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1};
    tbl[13] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1};

    repeat (2) @(posedge clk);
    #1;
    doReset();
    idle(10);

    // Single ALU push: pending immediately, written one cycle later, cleared after commit.
    applyStimulus('{1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1});
    checkVal("alu5_mask_e1", 32'(pending_mask[5]), 32'd1);
    checkVal("alu5_wr_en_e1", 32'(wr_en), 32'd0);
    idle(1);
    checkVal("alu5_wr_en_e2", 32'(wr_en), 32'd1);
    checkVal("alu5_wr_reg_e2", 32'(wr_reg), 32'd5);
    checkVal("alu5_wr_data_e2", wr_data, 32'hDEAD_BEEF);
    checkVal("alu5_mask_e2", 32'(pending_mask[5]), 32'd1);
    idle(1);
    checkVal("alu5_wr_en_e3", 32'(wr_en), 32'd0);
    checkVal("alu5_mask_e3", 32'(pending_mask[5]), 32'd0);
    checkVal("alu5_hold_data", wr_data, 32'hDEAD_BEEF);

    for (int i = 0; i < 14; i++) applyStimulus(tbl[i]);
    idle(6);
    checkVal("drain_empty", 32'(expQ.size()), 32'd0);
    checkVal("overflow_sticky", 32'(overflow), 32'd1);

    // Three entries queued, then a reset must flush them without any write.
    applyStimulus('{1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 1'b1});
    applyStimulus('{1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 1'b1});
    checkVal("pre_rst_queued", 32'(expQ.size()), 32'd3);
    doReset();
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
